// File: rtl/sw_op_fifo_if.sv
// rtl/sw_op_fifo_if.sv - push/pop handshake bundle between demux slot, op FIFO and switch access stage
interface sw_op_fifo_if #(
  parameter int OP_WIDTH = 32
) ();

  logic                wr_fifo;
  logic [OP_WIDTH-1:0] op_in;
  logic                rd_ready;
  logic                rd_valid;
  logic [4:0]          rd_addr;
  logic                rd_wr_rd_op;
  logic [7:0]          rd_wr_data;
  logic [7:0]          rd_op_id;

  // Demux/access-stage side: supplies ops and consumes the head
  modport master (
    output wr_fifo,
    output op_in,
    output rd_ready,
    input  rd_valid,
    input  rd_addr,
    input  rd_wr_rd_op,
    input  rd_wr_data,
    input  rd_op_id
  );

  // FIFO side
  modport slave (
    input  wr_fifo,
    input  op_in,
    input  rd_ready,
    output rd_valid,
    output rd_addr,
    output rd_wr_rd_op,
    output rd_wr_data,
    output rd_op_id
  );

endinterface

// File: rtl/sw_op_fifo.sv
// rtl/sw_op_fifo.sv - per-slot show-ahead op FIFO with decoded head fields and sticky overflow
module sw_op_fifo #(
  parameter  int OP_WIDTH = 32,
  parameter  int DEPTH    = 8,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  sw_op_fifo_if.slave      bus,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Only the low 22 bits carry an op; upper bits are deliberately discarded
  logic [OP_WIDTH-1:0] op_word;
  logic                unused_op;
  logic [21:0]         mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [21:0]         head;
  logic                pop;
  logic                push_ok;
  logic                drop;

  assign op_word   = bus.op_in;
  assign unused_op = ^op_word;

  // Status comes from the registered count only, never from live inputs
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  assign bus.rd_valid = ~empty;
  assign pop          = bus.rd_valid & bus.rd_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok      = bus.wr_fifo & (~full | pop);
  assign drop         = bus.wr_fifo & full & ~pop;

  assign head = mem[rptr];

  // Head decode, masked so stale array contents never leak out
  always_comb begin
    bus.rd_addr     = '0;
    bus.rd_wr_rd_op = 1'b0;
    bus.rd_wr_data  = '0;
    bus.rd_op_id    = '0;
    if (bus.rd_valid) begin
      bus.rd_addr     = head[21:17];
      bus.rd_wr_rd_op = head[16];
      bus.rd_wr_data  = head[15:8];
      bus.rd_op_id    = head[7:0];
    end
  end

  // Op storage; not reset since rd_valid masking hides it
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= op_word[21:0];
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
